music_play_ctrl: RTL and testbench
==================================

// Module: music_play_ctrl
// PURPOSE
//  Playback controller for the note-sequencer datapath. Generates the step tick at a selectable
//  tempo, walks a synchronous song ROM, and handles play/pause/stop/loop commands. Arbitrates the
//  4-bit note bus between the song and a live keypad. Drives note/speak to the tone generator.
// PARAMETERS
//  STEP_DIV  625000  clk cycles per step at tempo_sel=0 (5 MHz / 8)
//  SONG_LEN  128     number of ROM notes in the song (addresses 0..SONG_LEN-1)
//  ADDR_W    9       rom_addr width; must satisfy 2**ADDR_W > SONG_LEN
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  play       in   1       start from IDLE / resume from PAUSE (level sampled each clk)
//  pause      in   1       pause request
//  stop       in   1       stop request
//  loop       in   1       level; 1 = restart song at end
//  tempo_sel  in   2       step period = STEP_DIV >> tempo_sel
//  key_valid  in   1       keypad note request
//  key_note   in   4       keypad note index
//  rom_addr   out  ADDR_W  song ROM address (registered)
//  rom_note   in   4       ROM data; valid 1 clk after rom_addr changes
//  note       out  4       registered note index to tone generator; 0 = silence
//  speak      out  1       note != 0 (combinational from the note register)
//  state      out  2       0=IDLE 1=PLAY 2=PAUSE
//  step_tick  out  1       1-clk pulse per step
//  song_done  out  1       1-clk pulse at end of song
// BEHAVIOUR
//  Reset: state=IDLE; rom_addr=0; note=0; seq_note=0; step counter=0; step_tick=0; song_done=0.
//  Commands are sampled each clk. Priority is stop > pause > play.
//  - stop from any state: go to IDLE; rom_addr=0; counter=0; seq_note=0.
//  - pause in PLAY: go to PAUSE; counter and rom_addr hold. Ignored in IDLE and PAUSE.
//  - play in IDLE: go to PLAY with rom_addr=0, counter=0. play in PAUSE: go to PLAY and resume the
//    held counter and addr. Ignored in PLAY.
//  Step counter:
//  - Runs only in PLAY; cleared in IDLE; held in PAUSE.
//  - Terminal T = (STEP_DIV >> tempo_sel) - 1. When counter >= T: step_tick=1 and counter=0;
//    otherwise counter+1. The >= compare makes a mid-step tempo speedup tick on the next clk.
//  On step_tick:
//  - rom_addr < SONG_LEN: seq_note <= rom_note; rom_addr <= rom_addr+1.
//  - rom_addr == SONG_LEN (end of song): song_done=1 for 1 clk; seq_note <= 0; rom_addr <= 0.
//    If loop=1, stay in PLAY (one silent step, then rom[0]). If loop=0, go to IDLE.
//  - The first note appears one full step after play (1st tick).
//  Note output (registered, 1-clk latency):
//  - note <= key override (if enabled and key_valid) else (state==PLAY ? seq_note : 0).
//  - PAUSE mutes the output but keeps seq_note, so resume restores the same note.
//  Reset mid-operation behaves as stop plus clearing all outputs on the next edge.
// CONFIGURATION
//  MUSIC_KEY_OVERRIDE_EN defined:
//  - key_valid=1 forces note <= key_note in any state (key_note=0 gives silence).
//  - The sequence keeps advancing underneath in PLAY.
//  - On release, the note returns to the sequence/idle value on the next clk.
//  MUSIC_KEY_OVERRIDE_EN undefined: key_valid and key_note are ignored; note comes from the
//  sequence only.
// TESTING (bench: STEP_DIV=8, SONG_LEN=4, ROM[a]=a+1)
//  1. Assert rst 1 clk in PLAY -> next clk: note=0, speak=0, state=0, rom_addr=0, no ticks.
//  2. play pulse, tempo_sel=0 -> step_tick every 8 clks; note=1,2,3,4 on successive ticks;
//     speak=1.
//  3. loop=0 -> 5th tick: song_done pulse, state=IDLE, note=0.
//     loop=1 -> one silent step, then note=1 again.
//  4. pause 3 clks after the 2nd tick -> note=0, counter frozen.
//     play -> note=2 next clk; next tick arrives 5 clks after resume.
//  5. play+pause+stop in the same clk while in PLAY -> IDLE.
//     tempo_sel=2 in PLAY -> ticks every 2 clks; 8->2 switch mid-step ticks on the next clk.
//  6. With the macro: key_valid=1, key_note=9 in PLAY -> note=9 next clk while rom_addr keeps
//     advancing; release -> seq_note.
//     Without the macro -> note is unaffected.

Source files
------------

// File: rtl/music_play_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : music_play_ctrl                                                  |
// | Brief   : Tempo tick generator, song ROM walker and play/pause/stop/loop   |
// |           control with a registered note output. Optional live keypad      |
// |           override is enabled with the MUSIC_KEY_OVERRIDE_EN define.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module music_play_ctrl #(
    parameter int STEP_DIV = 625000,
    parameter int SONG_LEN = 128,
    parameter int ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop,
    input  logic [1:0]        tempo_sel,
    input  logic              key_valid,
    input  logic [3:0]        key_note,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_note,
    output logic [3:0]        note,
    output logic              speak,
    output logic [1:0]        state,
    output logic              step_tick,
    output logic              song_done
);

    localparam int CNT_W = $clog2(STEP_DIV + 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_play  = 2'd1;
    localparam logic [1:0] c_pause = 2'd2;

    localparam logic [CNT_W-1:0]  c_div      = CNT_W'(STEP_DIV);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] c_song_len = ADDR_W'(SONG_LEN);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_seq;
    logic [3:0]        r_note;
    logic              r_tick;
    logic              r_done;

    logic [CNT_W-1:0]  w_term;
    logic              w_step_end;
    logic              w_key_sel;
    logic [3:0]        w_note_nxt;

    // Greater-or-equal lets a tempo speedup mid-step end the step immediately.
    assign w_term     = (c_div >> tempo_sel) - c_cnt_one;
    assign w_step_end = (r_cnt >= w_term);

`ifdef MUSIC_KEY_OVERRIDE_EN
    assign w_key_sel = key_valid;
`else
    logic w_unused_key;
    assign w_unused_key = key_valid ^ (^key_note);
    assign w_key_sel    = 1'b0;
`endif

    // Pause mutes the output while r_seq keeps the note for resume.
    assign w_note_nxt = w_key_sel ? key_note :
                        ((r_state == c_play) ? r_seq : 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_seq   <= 4'd0;
            r_note  <= 4'd0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            r_note <= w_note_nxt;
            if (stop) begin
                r_state <= c_idle;
                r_cnt   <= '0;
                r_addr  <= '0;
                r_seq   <= 4'd0;
            end else begin
                case (r_state)
                    c_idle: begin
                        r_cnt <= '0;
                        if (play) begin
                            r_state <= c_play;
                            r_addr  <= '0;
                        end
                    end
                    c_pause: begin
                        if (play) begin
                            r_state <= c_play;
                        end
                    end
                    c_play: begin
                        if (pause) begin
                            r_state <= c_pause;
                        end else if (w_step_end) begin
                            r_tick <= 1'b1;
                            r_cnt  <= '0;
                            if (r_addr < c_song_len) begin
                                r_seq  <= rom_note;
                                r_addr <= r_addr + c_addr_one;
                            end else begin
                                // End of song: one silent step before rom[0] when looping.
                                r_done <= 1'b1;
                                r_seq  <= 4'd0;
                                r_addr <= '0;
                                if (!loop) begin
                                    r_state <= c_idle;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        r_state <= c_idle;
                        r_cnt   <= '0;
                        r_addr  <= '0;
                        r_seq   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign rom_addr  = r_addr;
    assign note      = r_note;
    assign speak     = (r_note != 4'd0);
    assign state     = r_state;
    assign step_tick = r_tick;
    assign song_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_music_play_ctrl.sv
`default_nettype none
// Self-checking bench for music_play_ctrl: directed vector table, corner
// sequences and randomized commands checked against a song-level model.
module tb_music_play_ctrl;

    localparam int STEP_DIV = 8;
    localparam int SONG_LEN = 4;
    localparam int ADDR_W   = 3;
`ifdef MUSIC_KEY_OVERRIDE_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic              clk;
    logic              rst, play, pause, stop, loop;
    logic [1:0]        tempo_sel;
    logic              key_valid;
    logic [3:0]        key_note;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_note;
    logic [3:0]        note;
    logic              speak;
    logic [1:0]        state;
    logic              step_tick, song_done;

    int n_checks = 0;
    int n_errors = 0;

    music_play_ctrl #(
        .STEP_DIV(STEP_DIV),
        .SONG_LEN(SONG_LEN),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .play     (play),
        .pause    (pause),
        .stop     (stop),
        .loop     (loop),
        .tempo_sel(tempo_sel),
        .key_valid(key_valid),
        .key_note (key_note),
        .rom_addr (rom_addr),
        .rom_note (rom_note),
        .note     (note),
        .speak    (speak),
        .state    (state),
        .step_tick(step_tick),
        .song_done(song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous song ROM: ROM[a] = a+1.
    always @(posedge clk) rom_note <= 4'(rom_addr) + 4'd1;

    // Song-level reference model.
    int song [SONG_LEN];
    int m_st, m_pos, m_elapsed, m_seq, m_note;
    bit m_tick, m_done;

    task automatic model_step();
        int period;
        int nxt_note;
        period   = STEP_DIV / (1 << tempo_sel);
        nxt_note = (KEY_EN && key_valid) ? int'(key_note) : ((m_st == 1) ? m_seq : 0);
        if (rst) begin
            m_st = 0; m_pos = 0; m_elapsed = 0; m_seq = 0; m_note = 0;
            m_tick = 0; m_done = 0;
        end else begin
            m_tick = 0;
            m_done = 0;
            m_note = nxt_note;
            if (stop) begin
                m_st = 0; m_pos = 0; m_elapsed = 0; m_seq = 0;
            end else if (m_st == 0) begin
                m_elapsed = 0;
                if (play) begin m_st = 1; m_pos = 0; end
            end else if (m_st == 2) begin
                if (play) m_st = 1;
            end else if (pause) begin
                m_st = 2;
            end else if (m_elapsed + 1 >= period) begin
                m_tick    = 1;
                m_elapsed = 0;
                if (m_pos < SONG_LEN) begin
                    m_seq = song[m_pos];
                    m_pos = m_pos + 1;
                end else begin
                    m_done = 1;
                    m_seq  = 0;
                    m_pos  = 0;
                    if (!loop) m_st = 0;
                end
            end else begin
                m_elapsed = m_elapsed + 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [11:0] act, exp;
        @(posedge clk);
        model_step();
        #1;
        act = {state, rom_addr, note, speak, step_tick, song_done};
        exp = {m_st[1:0], m_pos[2:0], m_note[3:0], (m_note != 0), m_tick, m_done};
        chk("model{state,addr,note,speak,tick,done}", 32'(act), 32'(exp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic cmd_pulse(input logic p, input logic pa, input logic s);
        play = p; pause = pa; stop = s;
        cycle();
        play = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    typedef struct {
        logic              rst, play;
        int                hold;
        logic [1:0]        e_state;
        logic [ADDR_W-1:0] e_addr;
        logic [3:0]        e_note;
        logic              e_tick, e_done;
    } vec_t;

    vec_t tbl [13];

    initial begin
        for (int i = 0; i < SONG_LEN; i++) song[i] = i + 1;
        m_st = 0; m_pos = 0; m_elapsed = 0; m_seq = 0; m_note = 0; m_tick = 0; m_done = 0;
        rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; loop = 1'b0;
        tempo_sel = 2'd0; key_valid = 1'b0; key_note = 4'd0;

        //          rst   play  hold st    addr  note  tick  done
        tbl[0]  = '{1'b1, 1'b0, 2, 2'd0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1, 2'd1, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 7, 2'd1, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1, 2'd1, 3'd1, 4'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1, 2'd1, 3'd1, 4'd1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 7, 2'd1, 3'd2, 4'd1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1, 2'd1, 3'd2, 4'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 7, 2'd1, 3'd3, 4'd2, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1, 2'd1, 3'd3, 4'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 7, 2'd1, 3'd4, 4'd3, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1, 2'd1, 3'd4, 4'd4, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 7, 2'd0, 3'd0, 4'd4, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1, 2'd0, 3'd0, 4'd0, 1'b0, 1'b0};

        for (int v = 0; v < 13; v++) begin
            rst  = tbl[v].rst;
            play = tbl[v].play;
            run(tbl[v].hold);
            chk($sformatf("vec%0d_state", v), 32'(state),     32'(tbl[v].e_state));
            chk($sformatf("vec%0d_addr", v),  32'(rom_addr),  32'(tbl[v].e_addr));
            chk($sformatf("vec%0d_note", v),  32'(note),      32'(tbl[v].e_note));
            chk($sformatf("vec%0d_tick", v),  32'(step_tick), 32'(tbl[v].e_tick));
            chk($sformatf("vec%0d_done", v),  32'(song_done), 32'(tbl[v].e_done));
        end
        rst = 1'b0; play = 1'b0;

        // Pause three clocks into the third step, then resume.
        cmd_pulse(1'b1, 1'b0, 1'b0);
        run(16);
        run(3);
        cmd_pulse(1'b0, 1'b1, 1'b0);
        run(1);
        chk("pause_note",  32'(note),  32'd0);
        chk("pause_state", 32'(state), 32'd2);
        run(4);
        chk("pause_addr",  32'(rom_addr),  32'd2);
        chk("pause_tick",  32'(step_tick), 32'd0);
        cmd_pulse(1'b1, 1'b0, 1'b0);
        run(1);
        chk("resume_note", 32'(note), 32'd2);
        run(3);
        chk("resume_no_tick", 32'(step_tick), 32'd0);
        run(1);
        chk("resume_tick", 32'(step_tick), 32'd1);

        // All commands at once: stop wins.
        cmd_pulse(1'b1, 1'b1, 1'b1);
        chk("stop_prio_state", 32'(state),    32'd0);
        chk("stop_prio_addr",  32'(rom_addr), 32'd0);
        run(1);
        chk("stop_note", 32'(note), 32'd0);

        // Fast tempo, then a mid-step speedup.
        tempo_sel = 2'd2;
        cmd_pulse(1'b1, 1'b0, 1'b0);
        run(1);
        chk("t2_gap", 32'(step_tick), 32'd0);
        run(1);
        chk("t2_tick1", 32'(step_tick), 32'd1);
        run(1);
        chk("t2_gap2", 32'(step_tick), 32'd0);
        run(1);
        chk("t2_tick2", 32'(step_tick), 32'd1);
        tempo_sel = 2'd0;
        run(4);
        chk("slow_no_tick", 32'(step_tick), 32'd0);
        tempo_sel = 2'd2;
        run(1);
        chk("speedup_tick", 32'(step_tick), 32'd1);
        chk("speedup_addr", 32'(rom_addr),  32'd3);
        tempo_sel = 2'd0;
        cmd_pulse(1'b0, 1'b0, 1'b1);

        // Looping: silent step at the end, then the song restarts.
        loop = 1'b1;
        cmd_pulse(1'b1, 1'b0, 1'b0);
        run(40);
        chk("loop_done",  32'(song_done), 32'd1);
        chk("loop_state", 32'(state),     32'd1);
        chk("loop_addr",  32'(rom_addr),  32'd0);
        run(1);
        chk("loop_silent", 32'(note), 32'd0);
        run(7);
        chk("loop_tick", 32'(step_tick), 32'd1);
        run(1);
        chk("loop_restart", 32'(note), 32'd1);
        loop = 1'b0;

        // Reset while playing.
        run(3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_note",  32'(note),      32'd0);
        chk("rst_speak", 32'(speak),     32'd0);
        chk("rst_state", 32'(state),     32'd0);
        chk("rst_addr",  32'(rom_addr),  32'd0);
        chk("rst_tick",  32'(step_tick), 32'd0);
        run(10);
        chk("rst_stays_idle", 32'(state),     32'd0);
        chk("rst_no_tick",    32'(step_tick), 32'd0);

        // Keypad request while the song advances.
        cmd_pulse(1'b1, 1'b0, 1'b0);
        run(10);
        key_valid = 1'b1;
        key_note  = 4'd9;
        run(1);
        chk("key_note", 32'(note), KEY_EN ? 32'd9 : 32'd1);
        run(8);
        chk("key_addr_adv", 32'(rom_addr), 32'd2);
        key_valid = 1'b0;
        run(1);
        chk("key_release", 32'(note), 32'd2);
        cmd_pulse(1'b0, 1'b0, 1'b1);

        // Randomized commands against the model.
        for (int c = 0; c < 2500; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            play  = ($urandom_range(0, 19) == 0);
            pause = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 89) == 0);
            if ($urandom_range(0, 99) == 0)  loop = ~loop;
            if ($urandom_range(0, 149) == 0) tempo_sel = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                key_valid = ~key_valid;
                key_note  = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
